// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encoding, the hardwired-zero address and default geometry.
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_CLEAR = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_e;

  localparam int RF_ZERO_ADDR = 0;
  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// Sequential clear engine: walks entries 0..DEPTH-1, zeroing one per cycle,
// then pulses clr_done for one cycle. Current state is exported for debug.
module regfile_clr_fsm
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = RF_DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output rf_state_e         state
);

  // One extra bit so the last-entry compare cannot wrap at DEPTH = 2**ADDR_W.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  logic [ADDR_W:0] clr_cnt;

  // State, counter and registered busy/done flags advance together.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= RF_IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= RF_CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        RF_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state    <= RF_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        RF_DONE: begin
          // clr_req is ignored here; it is not queued.
          state    <= RF_IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= RF_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = clr_busy;
  assign clr_addr = clr_cnt[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, two write
// ports (wr1 wins), optional hardwired-zero entry 0, optional write-to-read
// bypass, and a sequential clear engine.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DEF_DATA_W,
  parameter int ADDR_W   = RF_DEF_ADDR_W,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_conflict
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  rf_state_e         clr_state;
  logic              clear_active;
  logic              w0_ok;
  logic              w1_ok;

  // Address maps to a real, writable/readable entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < DEPTH_L);
    is_zero  = (ZERO_REG != 0) && (a == ADDR_W'(RF_ZERO_ADDR));
    return in_range && !is_zero;
  endfunction

  regfile_clr_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .reset_   (reset_),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (clr_state)
  );

  // User writes are dropped while the clear engine owns the array.
  assign clear_active = (clr_state == RF_CLEAR);
  assign w0_ok = wr0_en && addr_ok(wr0_addr) && !clear_active;
  assign w1_ok = wr1_en && addr_ok(wr1_addr) && !clear_active;

  // Storage: clear engine first, otherwise wr0 then wr1 so wr1 wins a tie.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (w0_ok) mem[wr0_addr] <= wr0_data;
      if (w1_ok) mem[wr1_addr] <= wr1_data;
    end
  end

  // Conflict flag: one-cycle pulse after both ports hit the same entry.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= w0_ok && w1_ok && (wr0_addr == wr1_addr);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux with optional forwarding of a write committing this edge.
    always_comb begin
      rdat = '0;
      if (addr_ok(ra)) begin
        rdat = mem[ra];
        if (BYPASS != 0) begin
          if (w0_ok && (wr0_addr == ra)) rdat = wr0_data;
          if (w1_ok && (wr1_addr == ra)) rdat = wr1_data;
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
  end

endmodule
